uart_rx_deserializer: RTL

- Receives asynchronous 8N1 serial data on the pin `rx_serial` and deserialises it into bytes.
- Presents each byte to the downstream SRAM controller on a valid/ready byte interface: `rx_data_out`, `rx_valid` and `rx_ready`, gated by `rx_enable`.
- Includes a 2-flop input synchroniser, majority-vote bit sampling, false-start rejection, framing-error detection, and a one-byte holding register with overrun detection.

---
 rtl/uart_rx_deserializer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote per bit, and a
// one-byte valid/ready holding register with framing and overrun error pulses.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    input  logic       rx_enable,
    input  logic       rx_ready,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] SAMP_A   = CW'(H - 1);
    localparam logic [CW-1:0] SAMP_B   = CW'(H);
    localparam logic [CW-1:0] SAMP_C   = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic          sync1_q;
    logic          rx_s_q;

    state_t        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [1:0]    samp_q;
    logic          frame_err_q;

    logic [7:0]    data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          overrun_q, overrun_d;

    logic          at_decide;
    logic          at_wrap;
    logic          vote;
    logic          byte_done;

    // Sync flops reset high so the idle line never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    assign at_decide = (clk_cnt_q == SAMP_C);
    assign at_wrap   = (clk_cnt_q == CNT_LAST);
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign byte_done = (state_q == STOP) && at_decide && vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            samp_q      <= '1;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (clk_cnt_q == SAMP_A) samp_q[0] <= rx_s_q;
            if (clk_cnt_q == SAMP_B) samp_q[1] <= rx_s_q;

            case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    if (rx_enable && !rx_s_q) state_q <= START;
                end
                START: begin
                    if (at_decide && vote) begin
                        state_q   <= IDLE;
                        clk_cnt_q <= '0;
                    end else if (at_wrap) begin
                        state_q   <= DATA;
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (at_decide) shift_q <= {vote, shift_q[7:1]};
                    if (at_wrap) begin
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                        else                   bit_cnt_q <= bit_cnt_q + 3'd1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                // Leave mid stop bit so a back-to-back start edge is not missed.
                STOP: begin
                    if (at_decide) begin
                        clk_cnt_q <= '0;
                        if (vote) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    clk_cnt_q <= '0;
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q && !rx_ready;
        overrun_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_data_out = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

endmodule
